// File: rtl/tmds_encoder_dvi_if.sv
// TMDS channel bus: de/din/ctrl into the encoder, 10-bit symbol out.
// master drives pixel/sync side; slave is the encoder.
interface tmds_encoder_dvi_if;
  logic       de;
  logic [7:0] din;
  logic [1:0] ctrl;
  logic [9:0] dout;

  modport master (
    output de,
    output din,
    output ctrl,
    input  dout
  );

  modport slave (
    input  de,
    input  din,
    input  ctrl,
    output dout
  );
endinterface

// File: rtl/tmds_encoder_dvi.sv
// DVI TMDS encoder, one channel: clk_pix, rst_pix (sync, high), tx.slave (de/din/ctrl -> dout).
// Define TMDS_PIPE_EN to register stage-2 decisions (latency 2 -> 3).
module tmds_encoder_dvi #(
  parameter logic [9:0] RST_SYM = 10'b1101010100
) (
  input  logic clk_pix,
  input  logic rst_pix,
  tmds_encoder_dvi_if.slave tx
);

  logic [3:0] n1d;
  logic       use_xnor;
  logic       qm_acc;
  logic [8:0] qm_c;

  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++)
      n1d = n1d + {3'b000, tx.din[i]};
    use_xnor = (n1d > 4'd4) |
               ((n1d == 4'd4) & ~tx.din[0]);
  end

  always_comb begin
    qm_acc  = tx.din[0];
    qm_c    = 9'd0;
    qm_c[0] = qm_acc;
    for (int i = 1; i < 8; i++) begin
      qm_acc  = use_xnor ? ~(qm_acc ^ tx.din[i])
                         : (qm_acc ^ tx.din[i]);
      qm_c[i] = qm_acc;
    end
    qm_c[8] = ~use_xnor;
  end

  logic [8:0] q_m;
  logic       de_d;
  logic [1:0] ctrl_d;

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      q_m    <= 9'd0;
      de_d   <= 1'b0;
      ctrl_d <= 2'b00;
    end else begin
      q_m    <= qm_c;
      de_d   <= tx.de;
      ctrl_d <= tx.ctrl;
    end
  end

  logic [3:0] n1q_c;
  logic [3:0] n0q_c;

  always_comb begin
    n1q_c = 4'd0;
    for (int i = 0; i < 8; i++)
      n1q_c = n1q_c + {3'b000, q_m[i]};
    n0q_c = 4'd8 - n1q_c;
  end

  logic [8:0] s2_qm;
  logic       s2_de;
  logic [1:0] s2_ctrl;
  logic [3:0] s2_n1;
  logic [3:0] s2_n0;

`ifdef TMDS_PIPE_EN
  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      s2_qm   <= 9'd0;
      s2_de   <= 1'b0;
      s2_ctrl <= 2'b00;
      s2_n1   <= 4'd0;
      s2_n0   <= 4'd8;
    end else begin
      s2_qm   <= q_m;
      s2_de   <= de_d;
      s2_ctrl <= ctrl_d;
      s2_n1   <= n1q_c;
      s2_n0   <= n0q_c;
    end
  end
`else
  assign s2_qm   = q_m;
  assign s2_de   = de_d;
  assign s2_ctrl = ctrl_d;
  assign s2_n1   = n1q_c;
  assign s2_n0   = n0q_c;
`endif

  logic signed [4:0] bias;
  logic signed [4:0] bias_n;
  logic signed [4:0] diff;
  logic signed [4:0] two_q8;
  logic signed [4:0] two_nq8;
  logic [9:0]        sym_n;
  logic [9:0]        ctl_sym;
  logic              sel_ctl;
  logic              sel_eq;
  logic              sel_inv;
  logic              sel_pass;

  assign diff    = $signed({1'b0, s2_n1}) -
                   $signed({1'b0, s2_n0});
  assign two_q8  = s2_qm[8] ? 5'sd2 : 5'sd0;
  assign two_nq8 = s2_qm[8] ? 5'sd0 : 5'sd2;

  // Mutually exclusive branch selects.
  always_comb begin
    sel_ctl  = ~s2_de;
    sel_eq   = s2_de &
               ((bias == 5'sd0) | (diff == 5'sd0));
    sel_inv  = s2_de & ~sel_eq &
               (((bias > 5'sd0) & (diff > 5'sd0)) |
                ((bias < 5'sd0) & (diff < 5'sd0)));
    sel_pass = s2_de & ~sel_eq & ~sel_inv;
  end

  always_comb begin
    ctl_sym = 10'b1101010100;
    unique case (s2_ctrl)
      2'b00: ctl_sym = 10'b1101010100;
      2'b01: ctl_sym = 10'b0010101011;
      2'b10: ctl_sym = 10'b0101010100;
      2'b11: ctl_sym = 10'b1010101011;
      default: ctl_sym = 10'b1101010100;
    endcase
  end

  always_comb begin
    sym_n  = ctl_sym;
    bias_n = 5'sd0;
    unique case (1'b1)
      sel_ctl: begin
        sym_n  = ctl_sym;
        bias_n = 5'sd0;
      end
      sel_eq: begin
        sym_n  = {~s2_qm[8], s2_qm[8],
                  s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
        bias_n = s2_qm[8] ? bias + diff : bias - diff;
      end
      sel_inv: begin
        sym_n  = {1'b1, s2_qm[8], ~s2_qm[7:0]};
        bias_n = bias + two_q8 - diff;
      end
      sel_pass: begin
        sym_n  = {1'b0, s2_qm[8], s2_qm[7:0]};
        bias_n = bias - two_nq8 + diff;
      end
      default: begin
        sym_n  = ctl_sym;
        bias_n = 5'sd0;
      end
    endcase
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      tx.dout <= RST_SYM;
      bias    <= 5'sd0;
    end else begin
      tx.dout <= sym_n;
      bias    <= bias_n;
    end
  end

endmodule

// File: tb/tb_tmds_encoder_dvi.sv
// Scoreboard bench for tmds_encoder_dvi: directed symbols plus random
// traffic against a behavioural encoder model.
module tb_tmds_encoder_dvi;

`ifdef TMDS_PIPE_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [9:0] RST_V = 10'h354;

  typedef struct {
    logic       de;
    logic [7:0] din;
    logic [1:0] ctrl;
    bit         has_c;
    logic [9:0] cval;
  } item_t;

  typedef struct {
    logic [9:0] sym;
    bit         is_data;
    logic [7:0] din;
  } exp_t;

  logic clk_pix;
  logic rst_pix;
  bit   chk_en;
  logic [9:0] chk_val;
  int   n_tests;
  int   n_fail;

  exp_t exp_q[$];

  tmds_encoder_dvi_if bus();

  tmds_encoder_dvi #(.RST_SYM(RST_V)) dut (
    .clk_pix (clk_pix),
    .rst_pix (rst_pix),
    .tx      (bus.slave)
  );

  initial begin
    clk_pix = 1'b0;
    forever #5 clk_pix = ~clk_pix;
  end

  function automatic logic [9:0] ctl_of(input logic [1:0] c);
    case (c)
      2'b00: return 10'h354;
      2'b01: return 10'h0AB;
      2'b10: return 10'h154;
      default: return 10'h2AB;
    endcase
  endfunction

  // Behavioural encoder: integer disparity arithmetic.
  function automatic void enc(input logic [7:0] d,
                              input int b_in,
                              output logic [9:0] sym,
                              output int b_out);
    int ones, n1, n0;
    bit xn, q8, inv;
    logic [7:0] qm;
    ones = $countones(d);
    xn = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm[0] = d[0];
    for (int i = 1; i < 8; i++)
      qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    q8 = !xn;
    n1 = $countones(qm);
    n0 = 8 - n1;
    if (b_in == 0 || n1 == n0) begin
      inv   = !q8;
      b_out = b_in + (q8 ? n1 - n0 : n0 - n1);
    end else if ((b_in > 0 && n1 > n0) ||
                 (b_in < 0 && n0 > n1)) begin
      inv   = 1'b1;
      b_out = b_in + 2 * int'(q8) + n0 - n1;
    end else begin
      inv   = 1'b0;
      b_out = b_in - 2 * int'(!q8) + n1 - n0;
    end
    sym = {inv, q8, inv ? ~qm : qm};
  endfunction

  // Model: pipeline of pending inputs, pushes the expected dout per edge.
  initial begin
    item_t pipe[DEPTH];
    item_t it;
    exp_t  e;
    int    mb, nb;
    logic [9:0] s;
    mb = 0;
    for (int i = 0; i < DEPTH; i++)
      pipe[i] = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h000};
    forever begin
      @(posedge clk_pix);
      if (rst_pix) begin
        for (int i = 0; i < DEPTH; i++)
          pipe[i] = '{1'b0, 8'h00, 2'b00, 1'b0, 10'h000};
        mb = 0;
        e = '{RST_V, 1'b0, 8'h00};
      end else begin
        it = pipe[DEPTH-1];
        for (int i = DEPTH - 1; i > 0; i--)
          pipe[i] = pipe[i-1];
        pipe[0] = '{bus.de, bus.din, bus.ctrl, chk_en, chk_val};
        if (it.de) begin
          enc(it.din, mb, s, nb);
          mb = nb;
          e = '{s, 1'b1, it.din};
        end else begin
          mb = 0;
          e = '{ctl_of(it.ctrl), 1'b0, 8'h00};
        end
        if (it.has_c) e.sym = it.cval;
      end
      exp_q.push_back(e);
    end
  end

  // Monitor: one symbol per clock.
  initial begin
    exp_t e;
    logic [7:0] v, dd;
    forever begin
      @(posedge clk_pix);
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL underflow: no expected entry at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.dout !== e.sym) begin
          n_fail++;
          $display("FAIL sym @%0t: dout=%h expected=%h",
                   $time, bus.dout, e.sym);
        end
        if (e.is_data) begin
          v = bus.dout[9] ? ~bus.dout[7:0] : bus.dout[7:0];
          dd[0] = v[0];
          for (int i = 1; i < 8; i++)
            dd[i] = bus.dout[8] ? (v[i] ^ v[i-1])
                                : ~(v[i] ^ v[i-1]);
          n_tests++;
          if (dd !== e.din) begin
            n_fail++;
            $display("FAIL decode @%0t: got=%h expected=%h",
                     $time, dd, e.din);
          end
        end
      end
    end
  end

  task automatic drv(input bit r, input bit d,
                     input logic [7:0] x, input logic [1:0] c,
                     input bit hc, input logic [9:0] cv);
    @(negedge clk_pix);
    rst_pix  = r;
    bus.de   = d;
    bus.din  = x;
    bus.ctrl = c;
    chk_en   = hc;
    chk_val  = cv;
  endtask

  initial begin
    bit d;
    n_tests  = 0;
    n_fail   = 0;
    rst_pix  = 1'b1;
    bus.de   = 1'b0;
    bus.din  = 8'h00;
    bus.ctrl = 2'b00;
    chk_en   = 1'b0;
    chk_val  = 10'h000;
    repeat (3) drv(1, 0, 8'h00, 2'b00, 0, 10'h0);
    repeat (3) drv(0, 0, 8'h00, 2'b00, 1, 10'h354);
    drv(0, 0, 8'h00, 2'b00, 1, 10'h354);
    drv(0, 0, 8'h00, 2'b01, 1, 10'h0AB);
    drv(0, 0, 8'h00, 2'b10, 1, 10'h154);
    drv(0, 0, 8'h00, 2'b11, 1, 10'h2AB);
    drv(0, 1, 8'h00, 2'b00, 1, 10'h100);
    drv(0, 1, 8'h00, 2'b00, 1, 10'h3FF);
    drv(0, 1, 8'h00, 2'b00, 1, 10'h100);
    drv(0, 0, 8'h00, 2'b00, 1, 10'h354);
    drv(0, 1, 8'hFF, 2'b00, 1, 10'h200);
    drv(0, 0, 8'h00, 2'b00, 1, 10'h354);
    drv(0, 1, 8'h00, 2'b00, 1, 10'h100);
    repeat (5) drv(0, 1, 8'($urandom), 2'b00, 0, 10'h0);
    drv(1, 1, 8'hA5, 2'b00, 0, 10'h0);
    drv(0, 1, 8'h00, 2'b00, 1, 10'h100);
    drv(0, 1, 8'h00, 2'b00, 1, 10'h3FF);
    d = 1'b1;
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(0, 9) == 0) d = ~d;
      drv(($urandom_range(0, 999) == 0), d,
          8'($urandom), 2'($urandom), 0, 10'h0);
    end
    repeat (DEPTH + 3) drv(0, 0, 8'h00, 2'b00, 0, 10'h0);
    @(negedge clk_pix);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
